// File: rtl/k_fifo_pkg.sv
// k_fifo_pkg: shared definitions for the FIFO write-port arbiter slice.
//   state_e   : arbiter FSM states (IDLE, XFER)
//   idx_width : width of a requester index for a given requester count
package k_fifo_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/k_rr_pick.sv
// k_rr_pick: combinational circular priority picker.
//   req    (in)  : request vector, one bit per requester
//   rr_ptr (in)  : highest-priority index for this search
//   any    (out) : at least one request is present
//   idx    (out) : first requesting index at or after rr_ptr (wrapping)
module k_rr_pick
    import k_fifo_pkg::*;
#(
    parameter int unsigned num_req = 4
) (
    input  logic [num_req-1:0]               req,
    input  logic [idx_width(num_req)-1:0]    rr_ptr,
    output logic                             any,
    output logic [idx_width(num_req)-1:0]    idx
);

    localparam int unsigned IDX_W = idx_width(num_req);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int unsigned j;
        any = |req;
        idx = '0;
        j   = 0;
        for (int unsigned off = num_req; off > 0; off--) begin
            j = (32'(rr_ptr) + off - 1) % num_req;
            if (req[j]) begin
                idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/k_fifo_wr_arb.sv
// k_fifo_wr_arb: round-robin, packet-atomic arbiter sharing one FIFO write
// port among num_req requesters in the wclk domain.
//   wclk, wrst_n : write clock, async active-low reset
//   req_valid    : per-requester valid
//   req_data     : packed data, requester i at [i*data_size +: data_size]
//   req_last     : per-requester end-of-packet, qualified by req_valid
//   req_ack      : per-requester beat accepted (one-hot or zero)
//   wfull        : FIFO full
//   wdata, wput  : FIFO write data / strobe
//   busy         : a grant is held
//   grant_id     : current owner, valid while busy
module k_fifo_wr_arb
    import k_fifo_pkg::*;
#(
    parameter int unsigned data_size = 8,
    parameter int unsigned num_req   = 4,
    parameter int unsigned max_burst = 4
) (
    input  logic                              wclk,
    input  logic                              wrst_n,
    input  logic [num_req-1:0]                req_valid,
    input  logic [num_req*data_size-1:0]      req_data,
    input  logic [num_req-1:0]                req_last,
    output logic [num_req-1:0]                req_ack,
    input  logic                              wfull,
    output logic [data_size-1:0]              wdata,
    output logic                              wput,
    output logic                              busy,
    output logic [idx_width(num_req)-1:0]     grant_id
);

    localparam int unsigned IDX_W = idx_width(num_req);
    localparam int unsigned BC_W  = $clog2(max_burst + 1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_grant_id;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [BC_W-1:0]    r_beat_cnt;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_own_valid;
    logic               w_own_last;
    logic [data_size-1:0] w_own_data;
    logic               w_beat;
    logic               w_release;
    logic [IDX_W-1:0]   w_next_rr;

    k_rr_pick #(
        .num_req (num_req)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (r_rr_ptr),
        .any    (w_any),
        .idx    (w_pick)
    );

    // Owner mux written as a compare loop so a non-power-of-two count never
    // indexes past the vectors.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[i*data_size +: data_size];
            end
        end
    end

    assign w_beat    = (r_state == XFER) && w_own_valid && !wfull;
    // Either cause alone releases; both together still give a single release.
    assign w_release = w_beat && (w_own_last || (r_beat_cnt == BC_W'(max_burst - 1)));
    assign w_next_rr = (r_grant_id == IDX_W'(num_req - 1)) ? '0 : r_grant_id + 1'b1;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_state    <= IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant_id <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_release) begin
                        r_state    <= IDLE;
                        r_beat_cnt <= '0;
                        r_rr_ptr   <= w_next_rr;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ack = '0;
        for (int unsigned i = 0; i < num_req; i++) begin
            req_ack[i] = w_beat && (r_grant_id == IDX_W'(i));
        end
    end

    assign busy     = (r_state == XFER);
    assign wput     = w_beat;
    assign wdata    = busy ? w_own_data : '0;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_k_fifo_wr_arb.sv
// tb_k_fifo_wr_arb: randomized bench for k_fifo_wr_arb, checked every cycle
// against a transaction-level model of grant ownership and round-robin order.
module tb_k_fifo_wr_arb;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned MB = 4;

    logic              wclk;
    logic              wrst_n;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ack;
    logic              wfull;
    logic [DW-1:0]     wdata;
    logic              wput;
    logic              busy;
    logic [1:0]        grant_id;

    k_fifo_wr_arb #(
        .data_size (DW),
        .num_req   (N),
        .max_burst (MB)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .wfull     (wfull),
        .wdata     (wdata),
        .wput      (wput),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: who owns the port, how many beats it has moved,
    // and who has priority next.
    bit          m_busy;
    int unsigned m_own;
    int unsigned m_beats;
    int unsigned m_rr;
    bit          e_wput;
    logic [N-1:0] e_ack;

    // Requester stimulus state.
    bit          en[N];
    int unsigned plen[N];     // beats per packet, 0 = never assert last
    int unsigned bidx[N];
    bit          rand_len;
    int unsigned drop_pct;
    int unsigned full_pct;
    logic [N-1:0] acked;

    task automatic model_reset();
        m_busy  = 0;
        m_own   = 0;
        m_beats = 0;
        m_rr    = 0;
        acked   = '0;
    endtask

    task automatic set_beat(input int unsigned i);
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i] = (plen[i] != 0) && (bidx[i] == plen[i] - 1);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                if (req_last[i]) begin
                    bidx[i] = 0;
                    if (rand_len) plen[i] = $urandom_range(0, 6);
                end else begin
                    bidx[i]++;
                end
                set_beat(i);
            end
            req_valid[i] = en[i] && ($urandom_range(0, 99) >= drop_pct);
        end
        wfull = ($urandom_range(0, 99) < full_pct);
    endtask

    task automatic check();
        e_wput = m_busy && req_valid[m_own] && !wfull;
        e_ack  = '0;
        if (e_wput) e_ack[m_own] = 1'b1;
        chk("busy", 32'(busy), 32'(m_busy));
        if (m_busy) chk("grant_id", 32'(grant_id), m_own);
        chk("wput", 32'(wput), 32'(e_wput));
        chk("req_ack", 32'(req_ack), 32'(e_ack));
        chk("wdata", 32'(wdata), m_busy ? 32'(req_data[m_own*DW +: DW]) : 32'd0);
        acked = e_ack;
    endtask

    task automatic model_step();
        if (m_busy) begin
            if (e_wput) begin
                m_beats++;
                if (req_last[m_own] || m_beats == MB) begin
                    m_busy = 0;
                    m_rr   = (m_own + 1) % N;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_valid[(m_rr + k) % N]) begin
                    m_own  = (m_rr + k) % N;
                    m_busy = 1;
                end
            end
            m_beats = 0;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        check();
        @(posedge wclk);
        model_step();
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned c = 0; c < n; c++) cycle();
    endtask

    task automatic setup(input logic [N-1:0] mask, input int unsigned len,
                         input int unsigned drop, input int unsigned full, input bit rl);
        for (int i = 0; i < N; i++) begin
            en[i]   = mask[i];
            plen[i] = len;
            bidx[i] = 0;
            set_beat(i);
        end
        drop_pct = drop;
        full_pct = full;
        rand_len = rl;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wput", 32'(wput), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        #1;
    endtask

    initial begin
        wrst_n    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        wfull     = 1'b0;
        model_reset();
        setup(4'b0000, 0, 0, 0, 0);
        #2;
        do_reset();

        // single requester, 3-beat packet
        setup(4'b0001, 3, 0, 0, 0);
        run(8);

        // all requesters streaming with no last: bursts capped at max_burst
        setup(4'b1111, 0, 0, 0, 0);
        run(30);

        // back-pressure from wfull
        setup(4'b1111, 0, 0, 50, 0);
        run(40);

        // owners dropping valid mid-packet
        setup(4'b1111, 6, 40, 0, 0);
        run(40);

        // last coinciding with the max_burst-th beat
        setup(4'b1111, MB, 0, 0, 0);
        run(25);

        // reset in the middle of a transfer
        setup(4'b1111, 0, 0, 0, 0);
        run(3);
        #2;
        do_reset();
        run(3);
        chk("post_rst_owner", 32'(grant_id), 32'd0);

        // long randomized run
        setup(4'b1111, 3, 20, 25, 1);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
